// File: rtl/pipelined_prefix_adder.sv
// Fully pipelined Kogge-Stone adder/subtractor on KPG combine cells, one register per prefix level.
// Define PPA_STATUS_FLAGS_EN to build the registered ovf/zero status flags; otherwise both read 0.
module pipelined_prefix_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Prefix levels over WIDTH+1 positions; position 0 carries the effective carry-in.
  localparam int LEVELS = $clog2(WIDTH + 1);

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b01;
  localparam logic [1:0] KPG_G = 2'b11;

  typedef logic [WIDTH:0][1:0] kpg_vec_t;

  function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
    return (hi != KPG_P) ? hi : lo;
  endfunction

  logic             adv;
  logic             accept;
  logic [LEVELS:0]  vld_q;
  logic [WIDTH-1:0] a_q   [LEVELS+1];
  logic [WIDTH-1:0] bx_q  [LEVELS+1];
  kpg_vec_t         kpg_q [LEVELS+1];
  kpg_vec_t         kpg_d [LEVELS+1];
  logic [WIDTH-1:0] bx_d;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Every stage moves together: the whole pipe stalls only when a result is stuck at the output.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // NOTE: every combinational output is fully assigned before any conditional or
  // per-bit update, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    bx_d        = sub ? ~b : b;
    kpg_d[0]    = '0;
    kpg_d[0][0] = (sub || cin) ? KPG_G : KPG_K;
    for (int i = 0; i < WIDTH; i++) begin
      kpg_d[0][i+1] = {a[i] & bx_d[i], a[i] | bx_d[i]};
    end
    for (int s = 1; s <= LEVELS; s++) begin
      kpg_d[s] = kpg_q[s-1];
      for (int i = 1 << (s - 1); i <= WIDTH; i++) begin
        kpg_d[s][i] = kpg_combine(kpg_q[s-1][i], kpg_q[s-1][i - (1 << (s - 1))]);
      end
    end
  end

  // NOTE: datapath pipeline registers carry no reset; vld_q alone says whether a
  // stage holds a live beat, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (accept) begin
        a_q[0]   <= a;
        bx_q[0]  <= bx_d;
        kpg_q[0] <= kpg_d[0];
      end
      for (int s = 1; s <= LEVELS; s++) begin
        if (vld_q[s-1]) begin
          a_q[s]   <= a_q[s-1];
          bx_q[s]  <= bx_q[s-1];
          kpg_q[s] <= kpg_d[s];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample
  // their predecessors' pre-edge values and shift as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[LEVELS-1:0], accept};
    end
  end

  // After the last level every position is resolved to K or G; bit 1 is the carry.
  always_comb begin
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = kpg_q[LEVELS][i][1];
    end
    sum_d  = a_q[LEVELS] ^ bx_q[LEVELS] ^ carry;
    cout_d = kpg_q[LEVELS][WIDTH][1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef PPA_STATUS_FLAGS_EN
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  // Signed overflow: operands agree in sign but the result does not.
  always_comb begin
    ovf_d  = (a_q[LEVELS][WIDTH-1] == bx_q[LEVELS][WIDTH-1]) &&
             (sum_d[WIDTH-1] != a_q[LEVELS][WIDTH-1]);
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv && vld_q[LEVELS]) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder: directed table, random stream against an
// arithmetic reference model, backpressure and mid-flight reset sequences, 8-bit instance.
module tb_pipelined_prefix_adder;

  localparam int W    = 16;
  localparam int LAT  = 6;
  localparam int W8   = 8;
  localparam int LAT8 = 5;
`ifdef PPA_STATUS_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;
  logic          in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [W8-1:0] a8, b8, sum8;

  pipelined_prefix_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_prefix_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands, no carry network.
  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
    bit     zero;
  } res_t;

  function automatic res_t model(input int w, input longint x, input longint y,
                                 input bit c, input bit s);
    res_t   r;
    longint full, sx, sy, cc, ut, st;
    full   = longint'(1) << w;
    cc     = c ? 1 : 0;
    sx     = (x >= full / 2) ? x - full : x;
    sy     = (y >= full / 2) ? y - full : y;
    ut     = s ? x - y : x + y + cc;
    st     = s ? sx - sy : sx + sy + cc;
    r.sum  = ut & (full - 1);
    r.cout = s ? (x >= y) : (ut >= full);
    r.ovf  = FLAGS && ((st >= full / 2) || (st < -(full / 2)));
    r.zero = FLAGS && (r.sum == 0);
    return r;
  endfunction

  // Scoreboard for the 16-bit instance: push on accept, pop on delivered result.
  res_t exp_q[$];
  res_t mon_e;
  int   n_out = 0;
  int   last_out_cyc = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_sum",  32'(sum),  32'(mon_e.sum));
          check("sb_cout", 32'(cout), 32'(mon_e.cout));
          check("sb_ovf",  32'(ovf),  32'(mon_e.ovf));
          check("sb_zero", 32'(zero), 32'(mon_e.zero));
          n_out++;
          last_out_cyc = cyc;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(W, a, b, cin, sub));
    end
  end

  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, ovf, zero;
  } vec_t;

  function automatic vec_t mkvec(string n, logic [W-1:0] xa, logic [W-1:0] xb, logic xc,
                                 logic xs, logic [W-1:0] s, logic co, logic ov, logic z);
    vec_t v;
    v.name = n; v.a = xa; v.b = xb; v.cin = xc; v.sub = xs;
    v.sum = s; v.cout = co; v.ovf = ov; v.zero = z;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the result on the outputs.
  task automatic send16(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic xs, output int lat);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    #2 check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send8(input logic [W8-1:0] xa, input logic [W8-1:0] xb, input logic xc,
                       input logic xs, output int lat);
    a8 = xa; b8 = xb; cin8 = xc; sub8 = xs; in_valid8 = 1'b1;
    #2 check("in_ready8_idle", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 4 * LAT8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rand_beat();
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  vec_t         vecs[9];
  int           lat, n0, start_cyc, sent;
  bit           acc;
  logic [W-1:0] held_sum;
  logic         held_cout;
  res_t         r8;
  logic [W8-1:0] ra8, rb8;
  logic          rc8, rs8;

  initial begin
    vecs[0] = mkvec("ffff_plus_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    vecs[1] = mkvec("5_minus_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    vecs[2] = mkvec("8000_minus_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    vecs[3] = mkvec("add_cin",       16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    vecs[4] = mkvec("7fff_plus_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vecs[5] = mkvec("0_minus_0",     16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    vecs[6] = mkvec("ffff_ffff_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vecs[7] = mkvec("8000_plus_8000",16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    vecs[8] = mkvec("sub_ignores_cin",16'h0003,16'h0007, 1'b1, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, single beats.
    for (int i = 0; i < 9; i++) begin
      send16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check({vecs[i].name, "_lat"},  32'(lat),  32'(LAT));
      check({vecs[i].name, "_sum"},  32'(sum),  32'(vecs[i].sum));
      check({vecs[i].name, "_cout"}, 32'(cout), 32'(vecs[i].cout));
      check({vecs[i].name, "_ovf"},  32'(ovf),  32'(vecs[i].ovf & FLAGS));
      check({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].zero & FLAGS));
    end
    @(posedge clk); #1;

    // 64 back-to-back random beats, full throughput.
    n0 = n_out;
    start_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      rand_beat();
      in_valid = 1'b1;
      #2 check("t3_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (i == 0) start_cyc = cyc;
    end
    in_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("t3_count",   32'(n_out - n0),               32'd64);
    check("t3_span",    32'(last_out_cyc - start_cyc), 32'(63 + LAT));
    check("t3_drained", 32'(exp_q.size()),             32'd0);

    // Backpressure: out_ready low for 10 cycles mid-stream.
    n0 = n_out;
    sent = 0;
    held_sum = '0;
    held_cout = 1'b0;
    rand_beat();
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      out_ready = !(c >= 12 && c < 22);
      #2;
      if (c >= 12 && c < 22) begin
        check("t4_in_ready",  32'(in_ready),  32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd1);
        if (c == 12) begin
          held_sum  = sum;
          held_cout = cout;
        end else begin
          check("t4_sum_hold",  32'(sum),  32'(held_sum));
          check("t4_cout_hold", 32'(cout), 32'(held_cout));
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 30) rand_beat();
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    check("t4_sent",    32'(sent),         32'd30);
    check("t4_count",   32'(n_out - n0),   32'd30);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with four beats in flight.
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("t5_pre_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_sum",       32'(sum),       32'd0);
    check("t5_cout",      32'(cout),      32'd0);
    check("t5_ovf",       32'(ovf),       32'd0);
    check("t5_zero",      32'(zero),      32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_post_in_ready", 32'(in_ready), 32'd1);
    send16(16'h0100, 16'h00FF, 1'b0, 1'b0, lat);
    check("t5_lat",  32'(lat),  32'(LAT));
    check("t5_sum1", 32'(sum),  32'h01FF);
    check("t5_cout1",32'(cout), 32'd0);
    @(posedge clk); #1;
    check("t5_no_stale", 32'(exp_q.size()), 32'd0);

    // 8-bit instance: LAT = 5.
    send8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    check("w8_7f_lat",  32'(lat),   32'(LAT8));
    check("w8_7f_sum",  32'(sum8),  32'h80);
    check("w8_7f_cout", 32'(cout8), 32'd0);
    check("w8_7f_ovf",  32'(ovf8),  32'(FLAGS));
    send8(8'h80, 8'h01, 1'b0, 1'b1, lat);
    check("w8_80m1_sum",  32'(sum8),  32'h7F);
    check("w8_80m1_cout", 32'(cout8), 32'd1);
    check("w8_80m1_ovf",  32'(ovf8),  32'(FLAGS));
    send8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    check("w8_ff_sum",  32'(sum8),  32'h00);
    check("w8_ff_cout", 32'(cout8), 32'd1);
    check("w8_ff_zero", 32'(zero8), 32'(FLAGS));
    for (int i = 0; i < 8; i++) begin
      ra8 = W8'($urandom); rb8 = W8'($urandom); rc8 = 1'($urandom); rs8 = 1'($urandom);
      r8 = model(W8, ra8, rb8, rc8, rs8);
      send8(ra8, rb8, rc8, rs8, lat);
      check("w8_rand_lat",  32'(lat),   32'(LAT8));
      check("w8_rand_sum",  32'(sum8),  32'(r8.sum));
      check("w8_rand_cout", 32'(cout8), 32'(r8.cout));
      check("w8_rand_ovf",  32'(ovf8),  32'(r8.ovf));
      check("w8_rand_zero", 32'(zero8), 32'(r8.zero));
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
